// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: load-use/RAW stall, branch flush and EX forwarding selects.
// Optional macro HAZARD_FWD_EN enables forwarding; without it a full RAW interlock is used.
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int BR_STAGE = 1,
    parameter int SELW     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rd,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic            br_taken,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            if_flush,
    output logic            idex_bubble,
    output logic [SELW-1:0] fwd_sel1,
    output logic [SELW-1:0] fwd_sel2,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    logic [NSTAGE-1:0] valid_r;
    logic [NSTAGE-1:0] regwrite_r;
    logic [NSTAGE-1:0] memread_r;
    logic [4:0]        rd_r [NSTAGE];
    logic [NSTAGE-2:0] match1_s;
    logic [NSTAGE-2:0] match2_s;
    logic              raw_s;
    logic              stall_s;
    logic              load_s;
    logic [31:0]       stall_cnt_r;
    logic [31:0]       flush_cnt_r;
    logic              unused_s;

    function automatic logic entry_match(input logic v, input logic rw, input logic [4:0] rd,
                                         input logic [4:0] src, input logic used);
        return v & rw & used & (rd != 5'd0) & (rd == src);
    endfunction

    // Per-entry RAW comparison against both ID sources; the WB entry needs no check.
    always_comb begin
        match1_s = '0;
        match2_s = '0;
        for (int k = 0; k < NSTAGE - 1; k++) begin
            match1_s[k] = entry_match(valid_r[k], regwrite_r[k], rd_r[k], id_rs1, id_rs1_used);
            match2_s[k] = entry_match(valid_r[k], regwrite_r[k], rd_r[k], id_rs2, id_rs2_used);
        end
    end

`ifdef HAZARD_FWD_EN
    logic [SELW-1:0] sel1_nxt_s;
    logic [SELW-1:0] sel2_nxt_s;
    logic [SELW-1:0] sel1_r;
    logic [SELW-1:0] sel2_r;

    assign raw_s = (match1_s[0] | match2_s[0]) & memread_r[0];

    // Youngest producer wins: scan oldest to youngest so the lowest index is kept.
    always_comb begin
        sel1_nxt_s = '0;
        sel2_nxt_s = '0;
        for (int k = NSTAGE - 2; k >= 0; k--) begin
            if (match1_s[k]) sel1_nxt_s = SELW'(k + 1);
            else             sel1_nxt_s = sel1_nxt_s;
            if (match2_s[k]) sel2_nxt_s = SELW'(k + 1);
            else             sel2_nxt_s = sel2_nxt_s;
        end
        if (!load_s) begin
            sel1_nxt_s = '0;
            sel2_nxt_s = '0;
        end else begin
            sel1_nxt_s = sel1_nxt_s;
            sel2_nxt_s = sel2_nxt_s;
        end
    end

    // Forward selects follow the consumer into EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel1_r <= '0;
            sel2_r <= '0;
        end else begin
            sel1_r <= sel1_nxt_s;
            sel2_r <= sel2_nxt_s;
        end
    end

    assign fwd_sel1 = sel1_r;
    assign fwd_sel2 = sel2_r;
`else
    assign raw_s    = |(match1_s | match2_s);
    assign fwd_sel1 = '0;
    assign fwd_sel2 = '0;
`endif

    // A taken branch overrides any stall; reset masks both.
    assign stall_s = raw_s & id_valid & ~br_taken & ~reset;
    assign load_s  = id_valid & ~stall_s & ~br_taken;

    // Scoreboard shift; wrong-path entries younger than the branch are squashed.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r    <= '0;
            regwrite_r <= '0;
            memread_r  <= '0;
            for (int k = 0; k < NSTAGE; k++) rd_r[k] <= 5'd0;
        end else begin
            valid_r[0]    <= load_s;
            regwrite_r[0] <= load_s & id_regwrite;
            memread_r[0]  <= load_s & id_memread;
            rd_r[0]       <= load_s ? id_rd : 5'd0;
            for (int k = 0; k < NSTAGE - 1; k++) begin
                valid_r[k+1]    <= valid_r[k] & ~(br_taken & (k < BR_STAGE));
                regwrite_r[k+1] <= regwrite_r[k];
                memread_r[k+1]  <= memread_r[k];
                rd_r[k+1]       <= rd_r[k];
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) stall_cnt_r <= stall_cnt_r + 32'd1;
            else                                            stall_cnt_r <= stall_cnt_r;
            if (br_taken && (flush_cnt_r != 32'hFFFF_FFFF)) flush_cnt_r <= flush_cnt_r + 32'd1;
            else                                             flush_cnt_r <= flush_cnt_r;
        end
    end

    assign pc_en       = ~stall_s;
    assign ifid_en     = ~stall_s;
    assign if_flush    = br_taken & ~reset;
    assign idex_bubble = reset | stall_s | br_taken;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;

    assign unused_s = ^{memread_r, valid_r[NSTAGE-1], regwrite_r[NSTAGE-1], rd_r[NSTAGE-1]};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations adapt to HAZARD_FWD_EN.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic        id_regwrite, id_memread, id_rs1_used, id_rs2_used;
    logic        br_taken;
    logic        pc_en, ifid_en, if_flush, idex_bubble;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_scoreboard #(.NSTAGE(3), .BR_STAGE(1), .SELW(2)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .br_taken(br_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .if_flush(if_flush), .idex_bubble(idex_bubble),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic id(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic rw, input logic mr,
                      input logic u1, input logic u2);
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_regwrite = rw; id_memread = mr; id_rs1_used = u1; id_rs2_used = u2;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        br_taken = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        reset = 1'b1;
        br_taken = 1'b1;
        id(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(); cyc();
        check("rst_pc_en", pc_en, 1);
        check("rst_ifid_en", ifid_en, 1);
        check("rst_if_flush", if_flush, 0);
        check("rst_idex_bubble", idex_bubble, 1);
        check("rst_fwd1", fwd_sel1, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        reset = 1'b0;
        br_taken = 1'b0;
        drain();

        // add x5 ; sub x8,x5,x5
        id(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        check("a_first_no_stall", pc_en, 1);
        check("a_first_idex_bubble", idex_bubble, 0);
        cyc();
        id(1'b1, 5'd8, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        check("a_c2_pc_en", pc_en, FWD);
        check("a_c2_ifid_en", ifid_en, FWD);
        check("a_c2_bubble", idex_bubble, 1 - FWD);
        cyc();
        check("a_c2_sel1", fwd_sel1, FWD);
        check("a_c2_sel2", fwd_sel2, FWD);
        check("a_c3_pc_en", pc_en, FWD);
        cyc();
        check("a_c3_sel1", fwd_sel1, 2 * FWD);
        check("a_c4_pc_en", pc_en, 1);
        cyc();
        check("a_c4_sel1", fwd_sel1, 0);
        exp_stall += 2 - 2 * FWD;
        check("a_stall_cnt", stall_cnt, exp_stall);
        drain();

        // ld x5 ; add x6,x5,x7
        id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        id(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        check("b_c2_pc_en", pc_en, 0);
        cyc();
        check("b_c2_sel1", fwd_sel1, 0);
        check("b_c3_pc_en", pc_en, FWD);
        cyc();
        check("b_c3_sel1", fwd_sel1, 2 * FWD);
        check("b_c3_sel2", fwd_sel2, 0);
        check("b_c4_pc_en", pc_en, 1);
        cyc();
        exp_stall += 2 - FWD;
        check("b_stall_cnt", stall_cnt, exp_stall);
        drain();

        // write x0 then use x0
        id(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc();
        id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("c_x0_pc_en", pc_en, 1);
        cyc();
        check("c_x0_sel1", fwd_sel1, 0);
        check("c_x0_sel2", fwd_sel2, 0);
        drain();

        // branch squashes younger entries, dependent ID must not stall
        id(1'b1, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        id(1'b1, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        br_taken = 1'b1;
        id(1'b1, 5'd12, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("d_if_flush", if_flush, 1);
        check("d_idex_bubble", idex_bubble, 1);
        check("d_pc_en", pc_en, 1);
        check("d_ifid_en", ifid_en, 1);
        cyc();
        exp_flush += 1;
        check("d_flush_cnt", flush_cnt, exp_flush);
        check("d_stall_cnt", stall_cnt, exp_stall);
        check("d_sel1_bubble", fwd_sel1, 0);
        br_taken = 1'b0;
        id(1'b1, 5'd13, 5'd11, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
        check("d_after_if_flush", if_flush, 0);
        check("d_after_pc_en", pc_en, 1);
        cyc();
        check("d_after_sel1", fwd_sel1, 0);
        check("d_after_sel2", fwd_sel2, 0);
        drain();

        // ld x5 in EX with branch the same cycle: flush wins
        id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        br_taken = 1'b1;
        id(1'b1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        check("e_pc_en", pc_en, 1);
        check("e_if_flush", if_flush, 1);
        check("e_idex_bubble", idex_bubble, 1);
        cyc();
        exp_flush += 1;
        check("e_stall_cnt", stall_cnt, exp_stall);
        check("e_flush_cnt", flush_cnt, exp_flush);
        drain();

        // invalid ID never stalls
        id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        id(1'b0, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        check("g_pc_en", pc_en, 1);
        check("g_idex_bubble", idex_bubble, 0);
        cyc();
        check("g_sel1", fwd_sel1, 0);
        check("g_stall_cnt", stall_cnt, exp_stall);
        drain();

        // reset in the middle of a stall
        id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        id(1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("f_stall_pc_en", pc_en, 0);
        reset = 1'b1;
        #1;
        check("f_rst_pc_en", pc_en, 1);
        check("f_rst_bubble", idex_bubble, 1);
        cyc();
        check("f_rst_stall_cnt", stall_cnt, 0);
        check("f_rst_flush_cnt", flush_cnt, 0);
        reset = 1'b0;
        #1;
        check("f_post_pc_en", pc_en, 1);
        check("f_post_ifid_en", ifid_en, 1);
        cyc();
        check("f_post_sel1", fwd_sel1, 0);
        check("f_post_stall_cnt", stall_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NSTAGE, default 3, number of tracked stages after ID (entry 0=EX, 1=MEM, ..., NSTAGE-1=WB), legal 2..6.
REQ-002 Parameter BR_STAGE, default 1, entry index at which branch/jump resolution is reported (1 = MEM), legal 0..NSTAGE-2.
REQ-003 Parameter SELW, default 2, width of forwarding selects; SHALL satisfy 2^SELW >= NSTAGE.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 id_valid  input  1  ID holds a real instruction.
REQ-007 id_rd, id_rs1, id_rs2  input  5 each  destination and source register fields of ID instruction.
REQ-008 id_regwrite, id_memread, id_rs1_used, id_rs2_used  input  1 each  ID decode qualifiers.
REQ-009 br_taken  input  1  instruction at entry BR_STAGE redirects PC this cycle.
REQ-010 pc_en, ifid_en  output  1 each  PC and IF/ID register load enables.
REQ-011 if_flush, idex_bubble  output  1 each  squash IF/ID contents; load NOP controls into ID/EX.
REQ-012 fwd_sel1, fwd_sel2  output  SELW each  registered EX operand source: 0 = ID/EX register-file value, k = result bus of entry k.
REQ-013 stall_cnt, flush_cnt  output  32 each  saturating event counters.

Function
REQ-014 Scoreboard SHALL hold NSTAGE entries {valid, rd, regwrite, memread}; every cycle entry k+1 <= entry k, last entry discarded.
REQ-015 Entry 0 SHALL load ID fields when id_valid & ~stall & ~br_taken, else load an invalid bubble.
REQ-016 A match SHALL require entry valid, regwrite=1, rd!=0, rd equal to a used source field.
REQ-017 Load-use stall SHALL assert combinationally when entry 0 matches with memread=1; duration exactly 1 cycle per load.
REQ-018 stall SHALL drive pc_en=0, ifid_en=0, idex_bubble=1 in the same cycle.
REQ-019 br_taken SHALL clear valid of entries 0..BR_STAGE-1 and assert if_flush=1, idex_bubble=1, pc_en=1 that cycle.
REQ-020 Simultaneous br_taken and stall: flush wins; stall suppressed, stall_cnt not incremented.
REQ-021 Forward select for each source SHALL be the youngest matching entry index k in 0..NSTAGE-2, registered as k+1 when ID advances, 0 when no match or bubble loaded.
REQ-022 Match at entry NSTAGE-1 SHALL yield select 0 (register file write-through covers it).
REQ-023 fwd_sel latency: one cycle, valid while consumer is in EX.
REQ-024 stall_cnt +1 per stall cycle, flush_cnt +1 per br_taken cycle; both hold at 32'hFFFFFFFF.
REQ-025 id_valid=0 SHALL never cause stall and SHALL insert a bubble.

Reset
REQ-026 While reset=1: all entries invalid, fwd_sel1/2=0, counters=0, if_flush=0, idex_bubble=1, pc_en=1, ifid_en=1.
REQ-027 Reset asserted mid-stall SHALL clear the stall in the following cycle; no pending state survives.
REQ-028 First cycle after reset release: no stall, no forwarding regardless of ID fields.

Configuration
REQ-029 Macro HAZARD_FWD_EN: defined -> behaviour per REQ-017/021.
REQ-030 HAZARD_FWD_EN undefined -> fwd_sel1/2 tied 0; stall asserts while any entry 0..NSTAGE-2 matches (RAW interlock until producer reaches WB); counters, flush unchanged.

Verification
REQ-031 ld x5 then add x6,x5,x7 back-to-back -> one stall cycle, stall_cnt=1, add sees fwd_sel1=2 (WB) in EX, fwd_sel2=0.
REQ-032 add x5 then sub x8,x5,x5 -> no stall, fwd_sel1=fwd_sel2=1 in EX.
REQ-033 br_taken=1 with valid entries 0..1 -> entry 0 invalid next cycle, if_flush=1, idex_bubble=1, flush_cnt=1.
REQ-034 ld x5 in EX, br_taken=1 same cycle, ID uses x5 -> no stall, flush applied, stall_cnt unchanged.
REQ-035 Write to x0 followed by use of x0 -> no stall, selects 0.
REQ-036 HAZARD_FWD_EN undefined, NSTAGE=3, add x5 then use x5 -> 2 stall cycles, selects always 0.
